// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   port (read only) and the data port (load/store). Grants at most one access
//   per cycle with round-robin tie-breaking, tracks the in-flight read through
//   the memory latency, routes the returned word to its owner and counts
//   contention cycles.
//
// Parameters
//   LAT  memory read latency (mem_en cycle -> valid mem_rdata), 1..4
//   MAW  memory word-address width
//   CW   contention counter width
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   if_req/if_addr              fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata   fetch grant, read-data valid, read data
//   d_req/d_we/d_addr/d_wdata   data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata      data grant, read-data valid, read data
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata         memory array interface
//   conflict_cnt                saturating count of contended eligible cycles
module mem_port_arbiter #(
  parameter int LAT = 2,
  parameter int MAW = 10,
  parameter int CW  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req,
  input  logic [31:0]    if_addr,
  output logic           if_gnt,
  output logic           if_rvalid,
  output logic [31:0]    if_rdata,
  input  logic           d_req,
  input  logic           d_we,
  input  logic [31:0]    d_addr,
  input  logic [31:0]    d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  output logic [31:0]    d_rdata,
  output logic           mem_en,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [31:0]    mem_wdata,
  input  logic [31:0]    mem_rdata,
  output logic [CW-1:0]  conflict_cnt
);

  typedef enum logic { S_IDLE, S_WAIT } state_e;
  typedef enum logic { P_IF, P_D } port_e;

  state_e      state;
  logic [1:0]  lat_cnt;
  port_e       owner;
  port_e       last_gnt;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;

  logic  eligible;
  logic  ret_cycle;
  logic  grant;
  logic  grant_rd;
  port_e win;

  // Byte-offset bits and bits above the memory range are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:MAW+2], if_addr[1:0],
                              d_addr[31:MAW+2], d_addr[1:0]};

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a signal unassigned and infer a latch.
  always_comb begin
    ret_cycle = !rst && (state == S_WAIT) && (lat_cnt == 2'd0);
    // A new access may issue while idle or in the cycle the read data returns,
    // so back-to-back reads overlap grant and return.
    eligible  = !rst && ((state == S_IDLE) || ret_cycle);

    // Lone requester wins; a tie goes to the port that was not granted last.
    win = P_IF;
    if (d_req && (!if_req || (last_gnt == P_IF))) win = P_D;

    grant    = eligible && (if_req || d_req);
    grant_rd = grant && ((win == P_IF) || !d_we);

    if_gnt    = grant && (win == P_IF);
    d_gnt     = grant && (win == P_D);
    mem_en    = grant;
    mem_we    = d_gnt && d_we;
    mem_addr  = (win == P_D) ? d_addr[MAW+1:2] : if_addr[MAW+1:2];
    mem_wdata = d_gnt ? d_wdata : 32'h0;

    if_rvalid = ret_cycle && (owner == P_IF);
    d_rvalid  = ret_cycle && (owner == P_D);
    // Returned word passes straight through; otherwise the last one is held.
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      lat_cnt      <= 2'd0;
      owner        <= P_IF;
      last_gnt     <= P_IF;
      conflict_cnt <= '0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      if (grant) last_gnt <= win;

      if (eligible && if_req && d_req && (conflict_cnt != {CW{1'b1}}))
        conflict_cnt <= conflict_cnt + 1'b1;

      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;

      if (grant_rd) begin
        owner   <= win;
        lat_cnt <= 2'(LAT - 1);
        state   <= S_WAIT;
      end else if (state == S_WAIT) begin
        if (lat_cnt == 2'd0) state   <= S_IDLE;
        else                 lat_cnt <= lat_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (LAT=2). A second
// instance with CW=4 shares all inputs to exercise counter saturation.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int MAW = 10;

  logic clk = 1'b0;
  logic rst;
  logic if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [MAW-1:0] mem_addr;
  logic [15:0] conflict_cnt;

  logic s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_mem_en, s_mem_we;
  logic [31:0] s_if_rdata, s_d_rdata, s_mem_wdata;
  logic [MAW-1:0] s_mem_addr;
  logic [3:0] s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(LAT), .MAW(MAW), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(conflict_cnt)
  );

  mem_port_arbiter #(.LAT(LAT), .MAW(MAW), .CW(4)) u_sat (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt),
    .if_rvalid(s_if_rvalid), .if_rdata(s_if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .conflict_cnt(s_conflict_cnt)
  );

  // Memory model: word i holds 0xC0DE0000+i, word 2 holds 0x00000013.
  // Read data appears exactly LAT cycles after the mem_en cycle.
  logic [31:0] mem [0:1023];
  logic [31:0] rpipe [0:LAT-1];
  logic mem_init = 1'b0;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + 32'(i);
      mem[2]   <= 32'h0000_0013;
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 32'hBAD0_BAD0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cyc();
    cyc();

    // Reset cycle with both requests up: nothing may be granted.
    if_req = 1'b1; d_req = 1'b1;
    settle();
    check("rst_if_gnt",   if_gnt,   0);
    check("rst_d_gnt",    d_gnt,    0);
    check("rst_mem_en",   mem_en,   0);
    check("rst_mem_we",   mem_we,   0);
    check("rst_rvalid",   {if_rvalid, d_rvalid}, 0);
    cyc();
    rst = 1'b0;
    idle_inputs();
    settle();
    check("rst_cnt", conflict_cnt, 0);

    // Lone fetch of word 2.
    if_req = 1'b1; if_addr = 32'h8;
    settle();
    check("f_gnt",      if_gnt,   1);
    check("f_d_gnt",    d_gnt,    0);
    check("f_mem_en",   mem_en,   1);
    check("f_mem_we",   mem_we,   0);
    check("f_mem_addr", mem_addr, 2);
    cyc();
    idle_inputs();
    settle();
    check("f_t1_gnt",    if_gnt,    0);
    check("f_t1_mem_en", mem_en,    0);
    check("f_t1_rvalid", if_rvalid, 0);
    cyc();
    settle();
    check("f_t2_rvalid", if_rvalid, 1);
    check("f_t2_rdata",  if_rdata,  32'h0000_0013);
    check("f_t2_drv",    d_rvalid,  0);
    cyc();

    // Both ports load continuously from reset: D, IF, D, IF.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic g_if, g_d;
      if (k < 7) begin
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
      end else begin
        idle_inputs();
      end
      settle();
      g_d  = (k < 7) && (k % 2 == 0) && ((k / 2) % 2 == 0);
      g_if = (k < 7) && (k % 2 == 0) && ((k / 2) % 2 == 1);
      check($sformatf("rr%0d_if_gnt", k), if_gnt, 32'(g_if));
      check($sformatf("rr%0d_d_gnt", k),  d_gnt,  32'(g_d));
      if (g_d)  check($sformatf("rr%0d_addr", k), mem_addr, 8);
      if (g_if) check($sformatf("rr%0d_addr", k), mem_addr, 4);
      check($sformatf("rr%0d_d_rv", k),  d_rvalid,  32'(k == 2 || k == 6));
      check($sformatf("rr%0d_if_rv", k), if_rvalid, 32'(k == 4 || k == 8));
      if (k == 2 || k == 6) check($sformatf("rr%0d_d_rdata", k), d_rdata, 32'hC0DE_0008);
      if (k == 4 || k == 8) check($sformatf("rr%0d_if_rdata", k), if_rdata, 32'hC0DE_0004);
      if (k == 7) check("rr_cnt", conflict_cnt, 4);
      cyc();
    end

    // Store then load to the same word; load uses ignored high/low bits.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    settle();
    check("st_gnt",   d_gnt,     1);
    check("st_we",    mem_we,    1);
    check("st_addr",  mem_addr,  32'h10);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc();
    d_we = 1'b0; d_addr = 32'hFFFF_F043; d_wdata = 32'h0;
    settle();
    check("ld_gnt",  d_gnt,    1);
    check("ld_we",   mem_we,   0);
    check("ld_addr", mem_addr, 32'h10);
    cyc();
    idle_inputs();
    settle();
    check("ld_t1_rv", d_rvalid, 0);
    cyc();
    settle();
    check("ld_rv",    d_rvalid,  1);
    check("ld_rdata", d_rdata,   32'hDEAD_BEEF);
    check("ld_if_rv", if_rvalid, 0);
    cyc();

    // Return-cycle overlap: d_req arrives mid-read and waits one cycle.
    if_req = 1'b1; if_addr = 32'h8;
    settle();
    check("ov_if_gnt", if_gnt, 1);
    cyc();
    idle_inputs();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    settle();
    check("ov_t1_d_gnt",  d_gnt,  0);
    check("ov_t1_mem_en", mem_en, 0);
    cyc();
    settle();
    check("ov_t2_d_gnt",  d_gnt,     1);
    check("ov_t2_if_rv",  if_rvalid, 1);
    check("ov_t2_rdata",  if_rdata,  32'h0000_0013);
    check("ov_t2_addr",   mem_addr,  8);
    cyc();
    idle_inputs();
    cyc();
    settle();
    check("ov_t4_d_rv",  d_rvalid, 1);
    check("ov_t4_rdata", d_rdata,  32'hC0DE_0008);
    cyc();

    // Reset one cycle into a read: the return is dropped.
    if_req = 1'b1; if_addr = 32'h10;
    settle();
    check("mr_gnt", if_gnt, 1);
    cyc();
    idle_inputs();
    rst = 1'b1;
    settle();
    check("mr_t1_en", mem_en, 0);
    cyc();
    rst = 1'b0;
    settle();
    check("mr_t2_rv", if_rvalid, 0);
    check("mr_t2_en", mem_en,    0);
    cyc();
    if_req = 1'b1; if_addr = 32'h8;
    settle();
    check("mr_t3_gnt", if_gnt, 1);
    cyc();
    idle_inputs();
    settle();
    check("mr_t4_rv", if_rvalid, 0);
    cyc();
    settle();
    check("mr_t5_rv",    if_rvalid, 1);
    check("mr_t5_rdata", if_rdata,  32'h0000_0013);
    cyc();

    // 20 contended eligible cycles: CW=16 reaches 20, CW=4 stops at 15.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      logic g, gd, rv, rvd;
      if_req = 1'b1; if_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = 32'h5A5A_5A5A;
      settle();
      g   = (k % 2 == 0);
      gd  = g && ((k / 2) % 2 == 0);
      rv  = (k >= 2) && g;
      rvd = rv && (((k - 2) / 2) % 2 == 0);
      check($sformatf("sat%0d_gnt_pair", k), {if_gnt, d_gnt}, {30'd0, g && !gd, gd});
      check($sformatf("sat%0d_s_gnt", k),    {s_if_gnt, s_d_gnt}, {30'd0, g && !gd, gd});
      check($sformatf("sat%0d_s_en", k),     {s_mem_en, s_mem_we}, {30'd0, g, 1'b0});
      check($sformatf("sat%0d_s_rv", k),     {s_if_rvalid, s_d_rvalid}, {30'd0, rv && !rvd, rvd});
      if (g) check($sformatf("sat%0d_s_addr", k), s_mem_addr, gd ? 8 : 4);
      if (gd) check($sformatf("sat%0d_s_wdata", k), s_mem_wdata, 32'h5A5A_5A5A);
      if (rvd) check($sformatf("sat%0d_s_d_rdata", k), s_d_rdata, 32'hC0DE_0008);
      if (rv && !rvd) check($sformatf("sat%0d_s_if_rdata", k), s_if_rdata, 32'hC0DE_0004);
      if (k == 27) check("sat_cnt4_k27", s_conflict_cnt, 14);
      if (k == 29) check("sat_cnt4_k29", s_conflict_cnt, 15);
      if (k == 39) begin
        check("sat_cnt4_end", s_conflict_cnt, 15);
        check("sat_cnt16_end", conflict_cnt, 20);
      end
      cyc();
    end
    idle_inputs();
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port and its data (load/store) port. It sits between the IF and MEM stages of the pipelined RISC-V core and a single 1024-word memory array. It grants at most one access at a time, applies round-robin tie-breaking, tracks the in-flight read through the memory latency and routes the returned word to its owner. It also counts contention cycles so the team can measure stall pressure.

## Interface
Parameters:
- LAT, 2, memory read latency in cycles from the mem_en cycle to valid mem_rdata; legal 1..4
- MAW, 10, memory word-address width
- CW, 16, width of the contention counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  if_rdata valid this cycle
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; held with d_we/d_addr/d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address
- d_wdata  in  32  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle
- d_rdata  out  32  loaded word
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable; valid only with mem_en
- mem_addr  out  MAW  word address = selected addr[MAW+1:2]
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid exactly LAT cycles after the mem_en cycle
- conflict_cnt  out  CW  saturating count of cycles where both requests were pending and one lost

## Operation
- States: IDLE (may grant), WAIT (read in flight). Registers: state, lat_cnt (2 bits), owner (IF/D), last_gnt (IF/D), conflict_cnt.
- Grant is combinational in a grant-eligible cycle: the cycle is in IDLE, or it is the WAIT cycle where the read data returns.
- Arbitration: only one requester pending -> grant it. Both pending -> grant the port not equal to last_gnt. last_gnt updates on every grant.
- Grant cycle: mem_en=1; mem_we, mem_addr and mem_wdata come from the winner; the winner's gnt=1 for exactly that cycle. Address bits [1:0] and bits above MAW+1 are ignored.
- Store grant (d_we=1): the write completes in the grant cycle. No rvalid. The next cycle is grant-eligible (IDLE).
- Read grant: owner is set to the winner, lat_cnt is set to LAT-1 and state goes to WAIT. With LAT=1, the next cycle is the return cycle.
- WAIT: lat_cnt decrements each cycle. The cycle with lat_cnt==0 is the return cycle:
  - the owner's rvalid is 1;
  - the owner's rdata equals mem_rdata (combinational pass-through);
  - a new grant may issue in the same cycle;
  - without a new read grant, state returns to IDLE.
- The fetch port only ever reads; if_req is treated as a load.
- rdata outputs hold the last mem_rdata pass-through value. They are meaningful only with rvalid.
- conflict_cnt increments in any grant-eligible cycle with if_req && d_req. It saturates at 2^CW-1 and does not wrap.

## Timing
- Reset (synchronous):
  - state=IDLE, lat_cnt=0, last_gnt=IF (so the first tie goes to D), conflict_cnt=0.
  - All gnt, rvalid, mem_en and mem_we are 0 during the reset cycle.
- Reset mid-read: the pending rvalid is dropped and never asserted. The next cycle after reset release is IDLE.
- Read latency: grant at cycle T -> rvalid at T+LAT.
- Back-to-back reads: sustained throughput is one read per LAT cycles, because grant and return overlap in cycle T+LAT.
- Stores: sustained throughput is one per cycle.
- A request arriving in a non-grant-eligible cycle waits. gnt is never asserted in a non-eligible cycle.
- Simultaneous events in a return cycle are all legal together:
  - rvalid to the old owner;
  - gnt to the new winner (which may be the same port);
  - a conflict_cnt increment.
- The rvalid of the two ports are never both 1. The gnt of the two ports are never both 1.

## Test plan
- Reset, then a lone fetch read (LAT=2):
  - stimulus: if_req=1, if_addr=0x8, memory word 2 = 0x00000013 at T;
  - response: if_gnt=1 and mem_addr=2 at T; if_rvalid=1 with if_rdata=0x00000013 at T+2; nothing at T+1.
- Both ports request continuously (d loads, LAT=2) from reset:
  - grants alternate D, IF, D, IF at T, T+2, T+4, T+6;
  - each rvalid goes to the correct port;
  - conflict_cnt=4 after T+6.
- Store then load to the same address:
  - stimulus: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF at T; load from 0x40 at T+1;
  - response: d_gnt at T and at T+1; d_rdata=0xDEADBEEF with d_rvalid at T+1+LAT.
- Return-cycle overlap:
  - stimulus: a fetch read is in flight; d_req rises in cycle T+1;
  - response: d_gnt waits until T+2, which is also the cycle if_rvalid=1.
- Reset asserted at T+1 during a read:
  - if_rvalid stays 0 at T+2;
  - a new if_req at T+3 is granted at T+3.
- Saturation with CW=4 forced:
  - stimulus: 20 contended grant-eligible cycles;
  - response: conflict_cnt stops at 15.
